imem_loader: RTL and testbench

Byte-stream boot loader that writes 16-bit instruction words into the CPU instruction memory, which is the write side of the instruction fetch path. It accepts a framed byte stream over a valid/ready handshake: a length byte, then word pairs sent high byte first, then an optional checksum byte. It holds the CPU in reset until a load has completed successfully.

---
 rtl/imem_loader.sv | 175 +++++++++++++++++
 tb/tb_imem_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream boot loader: frames {len, (hi, lo) x N [, csum]} into 16-bit instruction memory writes.
// Optional checksum byte and error state enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   loaded_count
);

    // state | meaning
    // IDLE  | after reset, waiting for start
    // LEN   | expecting the word-count byte
    // HI    | expecting the high byte of a word
    // LO    | expecting the low byte; accepting it writes the word
    // CSUM  | expecting the checksum byte
    // DONE  | load succeeded, CPU released
    // ERR   | checksum mismatch, CPU held
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        HI   = 3'd2,
        LO   = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    localparam int LW = (ADDR_W < 8) ? ADDR_W : 8;

    state_t            state, state_next;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   len_val;
    logic [7:0]        hi_byte;
    logic              accept;
    logic              last_word;
    logic              clr_cnt;
    logic              ld_len;
    logic              ld_hi;
    logic              wr_word;

    assign in_ready  = (state == LEN) || (state == HI) || (state == LO) || (state == CSUM);
    assign accept    = in_valid && in_ready;
    assign done      = (state == DONE);
    assign cpu_hold  = (state != DONE);
    assign last_word = ((loaded_count + 1'b1) == n_words);

    // A zero length byte stands for a full 2^ADDR_W-word image.
    always_comb begin
        len_val         = '0;
        len_val[LW-1:0] = in_data[LW-1:0];
        if (len_val == '0) begin
            len_val[ADDR_W] = 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    assign err = (state == ERR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= '0;
        end else if (clr_cnt) begin
            csum <= '0;
        end else if (accept && (state != CSUM)) begin
            csum <= csum ^ in_data;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        clr_cnt    = 1'b0;
        ld_len     = 1'b0;
        ld_hi      = 1'b0;
        wr_word    = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = LEN;
                    clr_cnt    = 1'b1;
                end
            end
            LEN: begin
                if (accept) begin
                    ld_len     = 1'b1;
                    state_next = HI;
                end
            end
            HI: begin
                if (accept) begin
                    ld_hi      = 1'b1;
                    state_next = LO;
                end
            end
            LO: begin
                if (accept) begin
                    wr_word = 1'b1;
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = DONE;
`endif
                    end else begin
                        state_next = HI;
                    end
                end
            end
            CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    state_next = (in_data == csum) ? DONE : ERR;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // loaded_count doubles as the word index into the image.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loaded_count <= '0;
            n_words      <= '0;
            hi_byte      <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= START_ADDR;
            imem_wdata   <= '0;
        end else begin
            imem_we <= wr_word;
            if (clr_cnt) begin
                loaded_count <= '0;
            end else if (wr_word) begin
                loaded_count <= loaded_count + 1'b1;
            end
            if (ld_len) begin
                n_words <= len_val;
            end
            if (ld_hi) begin
                hi_byte <= in_data;
            end
            if (wr_word) begin
                imem_addr  <= START_ADDR + loaded_count[ADDR_W-1:0];
                imem_wdata <= {hi_byte, in_data};
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (start address 00 and FE) share one stimulus stream;
// a frame-level model predicts every output each cycle. Honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    localparam int R_LEN  = 0;
    localparam int R_HI   = 1;
    localparam int R_LO   = 2;
    localparam int R_LAST = 3;
    localparam int R_CSUM = 4;
    localparam logic [7:0] SA0 = 8'h00;
    localparam logic [7:0] SA1 = 8'hFE;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;

    logic        in_ready_o [2];
    logic        imem_we_o  [2];
    logic [7:0]  imem_addr_o[2];
    logic [15:0] imem_wdata_o[2];
    logic        cpu_hold_o [2];
    logic        done_o     [2];
    logic        err_o      [2];
    logic [8:0]  count_o    [2];

    imem_loader #(.ADDR_W(8), .START_ADDR(SA0)) u0 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_o[0]), .imem_we(imem_we_o[0]), .imem_addr(imem_addr_o[0]),
        .imem_wdata(imem_wdata_o[0]), .cpu_hold(cpu_hold_o[0]), .done(done_o[0]),
        .err(err_o[0]), .loaded_count(count_o[0]));

    imem_loader #(.ADDR_W(8), .START_ADDR(SA1)) u1 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_o[1]), .imem_we(imem_we_o[1]), .imem_addr(imem_addr_o[1]),
        .imem_wdata(imem_wdata_o[1]), .cpu_hold(cpu_hold_o[1]), .done(done_o[1]),
        .err(err_o[1]), .loaded_count(count_o[1]));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int obs_writes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame-level model state
    logic        exp_busy, exp_done, exp_err, exp_hold;
    logic [8:0]  exp_cnt;
    logic [7:0]  exp_addr[2];
    logic [15:0] exp_data;
    logic [7:0]  m_hi;
    logic [7:0]  exp_csum;
    int          we_cyc;
    logic [15:0] wq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30) $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        exp_busy    = 1'b0;
        exp_done    = 1'b0;
        exp_err     = 1'b0;
        exp_hold    = 1'b1;
        exp_cnt     = '0;
        exp_addr[0] = SA0;
        exp_addr[1] = SA1;
        exp_data    = '0;
        we_cyc      = -10;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_in_ready", i), 32'(in_ready_o[i]), 32'(exp_busy));
            chk($sformatf("u%0d_done", i), 32'(done_o[i]), 32'(exp_done));
            chk($sformatf("u%0d_err", i), 32'(err_o[i]), 32'(exp_err));
            chk($sformatf("u%0d_cpu_hold", i), 32'(cpu_hold_o[i]), 32'(exp_hold));
            chk($sformatf("u%0d_loaded_count", i), 32'(count_o[i]), 32'(exp_cnt));
            chk($sformatf("u%0d_imem_we", i), 32'(imem_we_o[i]), 32'(cyc == we_cyc));
            chk($sformatf("u%0d_imem_addr", i), 32'(imem_addr_o[i]), 32'(exp_addr[i]));
            chk($sformatf("u%0d_imem_wdata", i), 32'(imem_wdata_o[i]), 32'(exp_data));
        end
        if (imem_we_o[0]) obs_writes++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (!exp_busy) begin
            exp_busy = 1'b1;
            exp_done = 1'b0;
            exp_err  = 1'b0;
            exp_hold = 1'b1;
            exp_cnt  = '0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int role, input bit rnd, input bit with_start);
        bit got;
        if (rnd) begin
            for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                tick();
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready_o[0]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("handshake_timeout", 32'(got), 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (with_start) start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        case (role)
            R_HI: m_hi = b;
            R_LO, R_LAST: begin
                exp_addr[0] = SA0 + exp_cnt[7:0];
                exp_addr[1] = SA1 + exp_cnt[7:0];
                exp_data    = {m_hi, b};
                exp_cnt     = exp_cnt + 9'd1;
                we_cyc      = cyc;
`ifndef IMEM_LOADER_CHECKSUM_EN
                if (role == R_LAST) begin
                    exp_busy = 1'b0;
                    exp_done = 1'b1;
                    exp_hold = 1'b0;
                end
`endif
            end
            R_CSUM: begin
                exp_busy = 1'b0;
                if (b == exp_csum) begin
                    exp_done = 1'b1;
                    exp_hold = 1'b0;
                end else begin
                    exp_err = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    // Sends a full frame built from wq; corrupt flips the checksum, inj adds ignored start pulses.
    task automatic send_frame(input logic [7:0] len, input bit corrupt, input bit rnd, input bit inj);
        int n;
        n = (len == 8'd0) ? 256 : int'(len);
        exp_csum = len;
        for (int i = 0; i < n; i++) exp_csum = exp_csum ^ wq[i][15:8] ^ wq[i][7:0];
        send_byte(len, R_LEN, rnd, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (inj && i == 0) pulse_start();
            send_byte(wq[i][15:8], R_HI, rnd, inj && i == 1);
            send_byte(wq[i][7:0], (i == n - 1) ? R_LAST : R_LO, rnd, 1'b0);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(corrupt ? (exp_csum ^ 8'h01) : exp_csum, R_CSUM, rnd, 1'b0);
`else
        if (corrupt) exp_csum = exp_csum ^ 8'h01;
`endif
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        m_hi     = 8'h00;
        exp_csum = 8'h00;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: idle, valid held without start
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 10; i++) tick();
        in_valid = 1'b0;
        chk("t1_in_ready", 32'(in_ready_o[0]), 32'd0);
        chk("t1_cpu_hold", 32'(cpu_hold_o[0]), 32'd1);

        // 2: two words back to back
        wq = '{16'h1234, 16'hABCD};
        pulse_start();
        send_frame(8'h02, 1'b0, 1'b0, 1'b0);
        chk("t2_csum_model", 32'(exp_csum), 32'h42);
        chk("t2_count", 32'(count_o[0]), 32'd2);
        chk("t2_addr_last", 32'(imem_addr_o[0]), 32'h01);
        chk("t2_wdata_last", 32'(imem_wdata_o[0]), 32'hABCD);
        chk("t2_done", 32'(done_o[0]), 32'd1);
        chk("t2_cpu_hold", 32'(cpu_hold_o[0]), 32'd0);

        // 3: bad checksum, then a good reload
        pulse_start();
        send_frame(8'h02, 1'b1, 1'b0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("t3_err", 32'(err_o[0]), 32'd1);
        chk("t3_done", 32'(done_o[0]), 32'd0);
        chk("t3_cpu_hold", 32'(cpu_hold_o[0]), 32'd1);
`else
        chk("t3_err", 32'(err_o[0]), 32'd0);
`endif
        chk("t3_count", 32'(count_o[0]), 32'd2);
        pulse_start();
        send_frame(8'h02, 1'b0, 1'b0, 1'b0);
        chk("t3_reload_done", 32'(done_o[0]), 32'd1);
        chk("t3_reload_err", 32'(err_o[0]), 32'd0);

        // 4: address wrap on the FE instance
        wq = '{16'h0001, 16'h0002, 16'h0003};
        pulse_start();
        send_frame(8'h03, 1'b0, 1'b0, 1'b0);
        chk("t4_u1_addr_wrap", 32'(imem_addr_o[1]), 32'h00);
        chk("t4_u1_wdata", 32'(imem_wdata_o[1]), 32'h0003);
        chk("t4_u1_count", 32'(count_o[1]), 32'd3);
        chk("t4_u0_addr", 32'(imem_addr_o[0]), 32'h02);

        // 5: random valid gaps, start pulses while busy
        wq = '{16'h1234, 16'hABCD};
        pulse_start();
        send_frame(8'h02, 1'b0, 1'b1, 1'b1);
        chk("t5_count", 32'(count_o[0]), 32'd2);
        chk("t5_wdata_last", 32'(imem_wdata_o[0]), 32'hABCD);
        chk("t5_done", 32'(done_o[0]), 32'd1);

        // 6: reset mid-load, then a full 256-word image
        wq = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
        pulse_start();
        send_byte(8'h04, R_LEN, 1'b0, 1'b0);
        send_byte(8'hC0, R_HI, 1'b0, 1'b0);
        send_byte(8'h01, R_LAST, 1'b0, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        exp_busy = 1'b1;
        exp_done = 1'b0;
        exp_hold = 1'b1;
`endif
        tick();
        reset = 1'b1;
        model_reset();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        chk("t6_in_ready", 32'(in_ready_o[0]), 32'd0);
        chk("t6_cpu_hold", 32'(cpu_hold_o[0]), 32'd1);
        chk("t6_count", 32'(count_o[0]), 32'd0);

        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back(16'(i * 257) ^ 16'h5A3C);
        obs_writes = 0;
        pulse_start();
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_write_count", 32'(obs_writes), 32'd256);
        chk("t6_count", 32'(count_o[0]), 32'd256);
        chk("t6_done", 32'(done_o[0]), 32'd1);
        chk("t6_u0_addr_last", 32'(imem_addr_o[0]), 32'hFF);
        chk("t6_u1_addr_last", 32'(imem_addr_o[1]), 32'hFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
